// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-ported data memory: fixed priority to the CPU port (A),
// starvation escape and burst lock for the debug/DMA port (B), read responses routed by owner tag.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STB_W      = 4,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wrdata,
    input  logic [STB_W-1:0]  a_wrstb,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rddata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wrdata,
    input  logic [STB_W-1:0]  b_wrstb,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rddata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic [STB_W-1:0]  mem_wrstb,
    input  logic [DATA_W-1:0] mem_rddata,
    output logic              b_starved
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        PRI_A  = 2'd0,
        PRI_B  = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [WAIT_W-1:0]       wait_nxt;
    logic [RD_LATENCY-1:0]   pipe_a;
    logic [RD_LATENCY-1:0]   pipe_b;
    logic                    push_a;
    logic                    push_b;

    // Grant decision, starvation counter and next state
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        wait_nxt  = '0;
        state_nxt = state;

        if (!rst) begin
            unique case (state)
                PRI_A: begin
                    a_gnt = a_req;
                    b_gnt = b_req && !a_req;
                end
                PRI_B: begin
                    b_gnt = b_req;
                    a_gnt = a_req && !b_req;
                end
                LOCK_B: begin
                    b_gnt = b_req;
                end
                default: begin
                    a_gnt = 1'b0;
                    b_gnt = 1'b0;
                end
            endcase
        end

        if (b_req && !b_gnt) begin
            if (wait_cnt != WAIT_W'(MAX_WAIT))
                wait_nxt = wait_cnt + WAIT_W'(1);
            else
                wait_nxt = wait_cnt;
        end

        unique case (state)
            PRI_A: begin
                if (b_gnt && b_lock)
                    state_nxt = LOCK_B;
                else if (wait_nxt == WAIT_W'(MAX_WAIT))
                    state_nxt = PRI_B;
            end
            PRI_B: begin
                if (b_gnt)
                    state_nxt = b_lock ? LOCK_B : PRI_A;
            end
            LOCK_B: begin
                if (!b_lock)
                    state_nxt = PRI_A;
            end
            default: state_nxt = PRI_A;
        endcase
    end

    // Memory mux follows the grant; strobes are gated so an idle cycle never writes
    always_comb begin
        mem_addr   = b_gnt ? b_addr : a_addr;
        mem_wrdata = b_gnt ? b_wrdata : a_wrdata;
        mem_wrstb  = '0;
        if (a_gnt)
            mem_wrstb = a_wrstb;
        else if (b_gnt)
            mem_wrstb = b_wrstb;
    end

    assign push_a = a_gnt && (a_wrstb == '0);
    assign push_b = b_gnt && (b_wrstb == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PRI_A;
            wait_cnt  <= '0;
            pipe_a    <= '0;
            pipe_b    <= '0;
            b_starved <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            pipe_a    <= RD_LATENCY'({pipe_a, push_a});
            pipe_b    <= RD_LATENCY'({pipe_b, push_b});
            b_starved <= (state_nxt == PRI_B);
        end
    end

    // Owner tag emerges from the last stage in step with the memory read data
    assign a_rvalid = pipe_a[RD_LATENCY-1];
    assign b_rvalid = pipe_b[RD_LATENCY-1];
    assign a_rddata = mem_rddata;
    assign b_rddata = mem_rddata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned RL = 2;
    localparam int unsigned MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, b_req, b_lock;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_wrdata, b_wrdata, mem_wrdata, mem_rddata, a_rddata, b_rddata;
    logic [SW-1:0] a_wrstb, b_wrstb, mem_wrstb;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, b_starved;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STB_W(SW), .RD_LATENCY(RL), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_wrdata(a_wrdata), .a_wrstb(a_wrstb),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rddata(a_rddata),
        .b_req(b_req), .b_addr(b_addr), .b_wrdata(b_wrdata), .b_wrstb(b_wrstb),
        .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rddata(b_rddata),
        .mem_addr(mem_addr), .mem_wrdata(mem_wrdata), .mem_wrstb(mem_wrstb),
        .mem_rddata(mem_rddata), .b_starved(b_starved)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 4) ? 32'hDEADBEEF : 32'hA500_0000 + 32'(i);
    endfunction

    // Memory device with RL-cycle read latency
    logic        load;
    logic [31:0] mem [0:63];
    logic [31:0] rdp [0:RL-1];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else begin
            for (int k = 0; k < SW; k++)
                if (mem_wrstb[k]) mem[mem_addr[7:2]][k*8 +: 8] <= mem_wrdata[k*8 +: 8];
        end
        rdp[0] <= mem[mem_addr[7:2]];
        for (int i = 1; i < RL; i++) rdp[i] <= rdp[i-1];
    end
    assign mem_rddata = rdp[RL-1];

    // Behavioural model state
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } rd_t;

    rd_t         rq[$];
    logic [31:0] smem [0:63];
    int          cyc, denied;
    bit          bprio, locked;
    int          n_vec, n_err;

    logic        o_ag, o_bg, o_arv, o_brv, o_bst;
    logic [31:0] o_ard, o_brd;
    logic [3:0]  o_ws;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit          ega, egb, eav, ebv;
        logic [31:0] ed, addr, wd;
        logic [3:0]  ws;
        int          idx;
        o_ag = a_gnt; o_bg = b_gnt; o_arv = a_rvalid; o_brv = b_rvalid;
        o_bst = b_starved; o_ard = a_rddata; o_brd = b_rddata; o_ws = mem_wrstb;

        ega = 1'b0; egb = 1'b0;
        if (!rst) begin
            if (locked) begin
                egb = b_req;
            end else if (bprio) begin
                egb = b_req; ega = a_req && !b_req;
            end else begin
                ega = a_req; egb = b_req && !a_req;
            end
        end
        eav = 1'b0; ebv = 1'b0; ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].id) ebv = 1'b1; else eav = 1'b1;
            ed = rq[0].data;
            void'(rq.pop_front());
        end
        addr = egb ? b_addr : a_addr;
        wd   = egb ? b_wrdata : a_wrdata;
        ws   = egb ? b_wrstb : a_wrstb;

        chk("a_gnt", a_gnt, ega);
        chk("b_gnt", b_gnt, egb);
        chk("b_starved", b_starved, bprio);
        chk("a_rvalid", a_rvalid, eav);
        chk("b_rvalid", b_rvalid, ebv);
        if (eav) chk("a_rddata", a_rddata, ed);
        if (ebv) chk("b_rddata", b_rddata, ed);
        if (ega || egb) begin
            chk("mem_addr", mem_addr, addr);
            chk("mem_wrstb", mem_wrstb, ws);
            if (ws != 0) chk("mem_wrdata", mem_wrdata, wd);
        end else begin
            chk("mem_wrstb_idle", mem_wrstb, 0);
        end

        if (rst) begin
            rq.delete(); denied = 0; bprio = 0; locked = 0;
        end else begin
            if (ega || egb) begin
                idx = int'(addr[7:2]);
                if (ws == 0) begin
                    rq.push_back('{due: cyc + RL, id: egb, data: smem[idx]});
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (ws[k]) smem[idx][k*8 +: 8] = wd[k*8 +: 8];
                end
            end
            if (b_req && !egb) denied = (denied < MW) ? denied + 1 : denied;
            else denied = 0;
            if (egb) begin
                bprio = 0; locked = b_lock;
            end else if (locked) begin
                if (!b_lock) locked = 0;
            end else if (!bprio && denied == MW) begin
                bprio = 1;
            end
        end
        cyc++;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 0; a_addr = '0; a_wrdata = '0; a_wrstb = '0;
        b_req = 0; b_addr = '0; b_wrdata = '0; b_wrstb = '0; b_lock = 0;
    endtask

    task automatic rd_a(input logic [31:0] ad);
        a_req = 1; a_addr = ad; a_wrstb = '0;
    endtask

    task automatic rd_b(input logic [31:0] ad);
        b_req = 1; b_addr = ad; b_wrstb = '0;
    endtask

    initial begin
        int          cnt, first_b, nb, na, lock_left;
        logic        arv_s [0:5];
        logic        brv_s [0:5];
        logic [31:0] ard_s [0:5];
        logic [31:0] brd_s [0:5];
        n_vec = 0; n_err = 0; cyc = 0; denied = 0; bprio = 0; locked = 0;
        for (int i = 0; i < 64; i++) smem[i] = init_val(i);
        idle();
        rst = 1; load = 1;
        cycle();
        load = 0;
        rd_a(32'h10);
        cycle();
        chk("rst_a_gnt", o_ag, 0);
        chk("rst_a_rvalid", o_arv, 0);
        chk("rst_b_starved", o_bst, 0);
        rst = 0; idle();

        // Single A read of 0x10
        rd_a(32'h10);
        cycle();
        chk("t1_a_gnt", o_ag, 1);
        idle();
        cycle();
        cycle();
        chk("t1_a_rvalid", o_arv, 1);
        chk("t1_a_rddata", o_ard, 32'hDEADBEEF);
        chk("t1_b_rvalid", o_brv, 0);

        // Quiet bus
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (o_ag || o_bg || o_bst || o_ws != 0) cnt++;
        end
        chk("idle_activity", cnt, 0);

        // Both requesting continuously
        rd_a(32'h40); rd_b(32'h44);
        first_b = -1; nb = 0;
        for (int i = 0; i < 27; i++) begin
            cycle();
            if (o_bg) begin
                if (first_b < 0) first_b = i;
                nb++;
                chk("starve_flag", o_bst, 1);
            end
        end
        chk("starve_first", first_b, 8);
        chk("starve_count", nb, 3);
        idle();
        for (int i = 0; i < 4; i++) cycle();

        // Locked B write of 0xAA to 0x20 while A keeps requesting
        rd_a(32'h30);
        b_req = 1; b_addr = 32'h20; b_wrdata = 32'h0000_00AA; b_wrstb = 4'b0001; b_lock = 1;
        na = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (o_bg) break;
            if (o_ag) na++;
            if (i == 19) na = -1;
        end
        chk("lock_a_before_b", na, 8);
        b_req = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("lock_a_held", o_ag, 0);
        end
        b_lock = 0;
        cycle();
        chk("lock_exit_a", o_ag, 0);
        cycle();
        chk("lock_after_a", o_ag, 1);
        idle();
        for (int i = 0; i < 3; i++) cycle();
        rd_a(32'h20);
        cycle();
        idle();
        cycle();
        cycle();
        chk("lock_wr_data", o_ard, 32'hA500_00AA);

        // Alternating A/B/A reads
        for (int j = 0; j < 6; j++) begin
            idle();
            if (j == 0) rd_a(32'h0);
            if (j == 1) rd_b(32'h4);
            if (j == 2) rd_a(32'h8);
            cycle();
            arv_s[j] = o_arv; brv_s[j] = o_brv; ard_s[j] = o_ard; brd_s[j] = o_brd;
        end
        chk("alt_rv0", {arv_s[2], brv_s[2]}, 2'b10);
        chk("alt_rv1", {arv_s[3], brv_s[3]}, 2'b01);
        chk("alt_rv2", {arv_s[4], brv_s[4]}, 2'b10);
        chk("alt_d0", ard_s[2], 32'hA500_0000);
        chk("alt_d1", brd_s[3], 32'hA500_0001);
        chk("alt_d2", ard_s[4], 32'hA500_0002);

        // Reset with reads in flight
        idle(); rd_a(32'h10); cycle();
        idle(); rd_b(32'h14); cycle();
        idle(); rst = 1; cycle();
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (o_arv || o_brv) cnt++;
        end
        chk("rst_flush_rvalid", cnt, 0);
        chk("rst_flush_starved", o_bst, 0);
        rd_a(32'h10); cycle();
        idle(); cycle(); cycle();
        chk("rst_after_rvalid", o_arv, 1);
        chk("rst_after_rddata", o_ard, 32'hDEADBEEF);

        // Random traffic
        lock_left = 0;
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom % 300) == 0;
            a_req    = ($urandom % 3) != 0;
            a_addr   = $urandom & 32'hFC;
            a_wrdata = $urandom;
            a_wrstb  = ($urandom % 2) ? 4'($urandom) : 4'h0;
            b_req    = ($urandom % 2) != 0;
            b_addr   = $urandom & 32'hFC;
            b_wrdata = $urandom;
            b_wrstb  = ($urandom % 2) ? 4'($urandom) : 4'h0;
            if (lock_left > 0) begin
                lock_left--; b_lock = 1;
            end else if ($urandom % 40 == 0) begin
                lock_left = int'($urandom_range(1, 8)); b_lock = 1;
            end else begin
                b_lock = 0;
            end
            cycle();
        end
        idle(); rst = 0;
        for (int i = 0; i < 4; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters:
  - Port A: the CPU core's data port.
  - Port B: a debug/DMA master, e.g. a UART program loader or a memory dumper.
- Sits between both masters and the data memory on the top level.
- Arbitration is fixed-priority A, with starvation protection and an optional lock for B bursts.
- Routes each read response back to the requester that issued it.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STB_W, 4, write byte-strobe width (DATA_W/8).
- RD_LATENCY, 1, cycles from accepted read to valid memory read data (>=1).
- MAX_WAIT, 8, consecutive denied B-request cycles before B takes priority (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_req  in  1  A requests access this cycle
- a_addr  in  ADDR_W  A address
- a_wrdata  in  DATA_W  A write data
- a_wrstb  in  STB_W  A byte strobes; all-zero means read
- a_gnt  out  1  A request accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rddata  out  DATA_W  A read data
- b_req, b_addr, b_wrdata, b_wrstb, b_gnt, b_rvalid, b_rddata: same as the A ports, for B
- b_lock  in  1  B requests exclusive ownership while high
- mem_addr  out  ADDR_W  memory address
- mem_wrdata  out  DATA_W  memory write data
- mem_wrstb  out  STB_W  memory byte strobes
- mem_rddata  in  DATA_W  memory read data, RD_LATENCY cycles after address
- b_starved  out  1  B priority mode active (debug)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Clock and reset ports are clk and rst.

Reset:
- All registered state clears on the first rising clk edge with rst=1:
  - state = PRI_A
  - wait_cnt = 0
  - read-tag pipeline empty
  - a_rvalid = b_rvalid = 0
  - b_starved = 0
- While rst=1: a_gnt = b_gnt = 0 and mem_wrstb = 0.
- Reset mid-transaction discards all in-flight read responses. No rvalid is produced for them.

Grant (combinational, same cycle):
- A request is accepted in the cycle where req and gnt are both high.
- At most one grant per cycle.
- The mux follows the grant. With no grant, the mux selects A, but mem_wrstb is forced to 0 so no spurious write can occur.

States:
- PRI_A:
  - Grant A if a_req; else grant B if b_req.
  - Go to PRI_B when wait_cnt reaches MAX_WAIT.
- PRI_B:
  - Grant B if b_req; else grant A if a_req.
  - Return to PRI_A after the first B grant, unless b_lock=1.
- LOCK_B:
  - Grant only B; A is never granted.
  - Entered from any state on a B grant with b_lock=1.
  - Left when b_lock=0 in a cycle, back to PRI_A. B may still be granted in that exit cycle.

wait_cnt:
- Increments each cycle b_req=1 and b_gnt=0, saturating at MAX_WAIT.
- Clears on any B grant, and on any cycle b_req=0.
- b_starved = (state==PRI_B).

Read return:
- An accepted read (wrstb==0) pushes owner tag {valid, id} into a RD_LATENCY-deep shift register.
- At the pipeline output: x_rvalid=1 for the matching owner for exactly one cycle.
- x_rddata = mem_rddata in every cycle; meaningful only when x_rvalid=1.
- Writes produce no rvalid. Write completes at the grant edge.
- Back-to-back reads from alternating owners return in issue order, one per cycle, with no bubbles.

Simultaneous events:
- a_req and b_req in PRI_A: A wins.
- Both in PRI_B: B wins.
- b_lock asserted without b_req: no effect.

Test Plan:
- Reset, then a_req read at 0x10 with memory holding 0xDEADBEEF there (RD_LATENCY=1):
  - a_gnt=1 the same cycle.
  - a_rvalid=1 with a_rddata=0xDEADBEEF exactly one cycle later.
  - b_rvalid stays 0.
- a_req and b_req both held high continuously (MAX_WAIT=8):
  - A granted 8 cycles.
  - Then b_starved=1 and b_gnt=1 for one cycle.
  - Then A resumes; pattern repeats every 9 cycles.
- B write 0x0000_00AA, wrstb=4'b0001, to 0x20 with b_lock=1 while a_req is held:
  - LOCK_B entered; a_gnt=0 for as long as b_lock=1.
  - Drop b_lock: A granted the next cycle.
  - mem_wrstb=0 in all ungranted cycles.
- Alternating A read 0x0, B read 0x4, A read 0x8 on consecutive cycles (RD_LATENCY=2):
  - rvalid pattern is a, b, a on the three cycles starting 2 after the first grant.
  - Returned data matches each address.
- Assert rst for one cycle while two reads are in flight:
  - No rvalid is observed afterwards.
  - state=PRI_A and wait_cnt=0.
  - The next A read returns normally.
- No requests for 20 cycles:
  - mem_wrstb=0, a_gnt=b_gnt=0, b_starved=0 throughout.
